// File: rtl/ball_motion_engine.sv
// Pong ball kinematics: fixed-point position, LFSR-directed serve, wall/paddle reflection, speed-up and scoring.
// Latency: position, moving and event pulses update on the clk edge where tick=1; a serve moves to MOVE on the next edge.
// Backpressure: none; tick is a free-running frame strobe and serve is honoured only while idle.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   tick              one-cycle frame-step enable
//   serve             start request (IDLE only)
//   lpad_y, rpad_y    paddle top rows, sampled on the tick edge
//   ball_x, ball_y    integer part of the ball's top-left corner
//   moving            high while the ball is in play
//   wall_hit, paddle_hit, score_l, score_r   one-cycle event pulses
module ball_motion_engine #(
    parameter int FIELD_W    = 64,
    parameter int FIELD_H    = 64,
    parameter int BALL_SIZE  = 2,
    parameter int PADDLE_H   = 12,
    parameter int LPAD_X     = 2,
    parameter int RPAD_X     = 60,
    parameter int FRAC       = 4,
    parameter int SPEED0     = 16,
    parameter int SPEED_INC  = 2,
    parameter int SPEED_MAX  = 48,
    parameter int HOLD_TICKS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       serve,
    input  logic [$clog2(FIELD_H)-1:0] lpad_y,
    input  logic [$clog2(FIELD_H)-1:0] rpad_y,
    output logic [$clog2(FIELD_W)-1:0] ball_x,
    output logic [$clog2(FIELD_H)-1:0] ball_y,
    output logic                       moving,
    output logic                       wall_hit,
    output logic                       paddle_hit,
    output logic                       score_l,
    output logic                       score_r
);
    localparam int XW = $clog2(FIELD_W);
    localparam int YW = $clog2(FIELD_H);
    localparam int IW = (XW > YW) ? XW : YW;
    // Two guard bits: one for sign, one so an overshoot past the field edge cannot wrap.
    localparam int PW = IW + FRAC + 2;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef logic signed [PW-1:0] fx_t;

    // Constants suffixed _FX are in fixed point; the others are whole pixels.
    localparam fx_t CX_FX     = fx_t'(((FIELD_W - BALL_SIZE) / 2) << FRAC);
    localparam fx_t CY_FX     = fx_t'(((FIELD_H - BALL_SIZE) / 2) << FRAC);
    localparam fx_t RFACE     = fx_t'(RPAD_X - BALL_SIZE);
    localparam fx_t RFACE_FX  = fx_t'((RPAD_X - BALL_SIZE) << FRAC);
    localparam fx_t LFACE     = fx_t'(LPAD_X);
    localparam fx_t LFACE_FX  = fx_t'(LPAD_X << FRAC);
    localparam fx_t XLIM      = fx_t'(FIELD_W - BALL_SIZE);
    localparam fx_t YLIM      = fx_t'(FIELD_H - BALL_SIZE);
    localparam fx_t YLIM_FX   = fx_t'((FIELD_H - BALL_SIZE) << FRAC);
    localparam fx_t PAD_SPAN  = fx_t'(PADDLE_H - 1);
    localparam fx_t BALL_SPAN = fx_t'(BALL_SIZE - 1);
    localparam fx_t SPD0      = fx_t'(SPEED0);
    localparam fx_t SINC      = fx_t'(SPEED_INC);
    localparam fx_t SMAX      = fx_t'(SPEED_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SCORED} state_t;

    state_t        state;
    fx_t           px, py, vx, vy;
    logic [7:0]    lfsr;
    logic [HW-1:0] hold_cnt;

    fx_t  nx, ny, nx_i, ny_i, px_i;
    fx_t  vx_mag, vy_mag, vx_bump, vy_srv, lpad_s, rpad_s;
    logic r_hit, r_exit, l_hit, l_exit;

    always_comb begin
        nx      = px + vx;
        ny      = py + vy;
        nx_i    = nx >>> FRAC;
        ny_i    = ny >>> FRAC;
        px_i    = px >>> FRAC;
        vx_mag  = vx[PW-1] ? -vx : vx;
        vy_mag  = vy[PW-1] ? -vy : vy;
        vx_bump = (vx_mag + SINC > SMAX) ? SMAX : vx_mag + SINC;
        vy_srv  = fx_t'(8) + fx_t'({lfsr[2:1], 2'b00});
        lpad_s  = fx_t'(lpad_y);
        rpad_s  = fx_t'(rpad_y);
        // A paddle only catches a ball that starts this step at or before its face
        // and whose rows at the new position overlap the paddle rows.
        r_hit   = !vx[PW-1] && (nx_i >= RFACE) && (px_i <= RFACE)
                  && (ny_i <= rpad_s + PAD_SPAN) && (ny_i + BALL_SPAN >= rpad_s);
        r_exit  = !vx[PW-1] && !r_hit && (nx_i > XLIM);
        l_hit   = vx[PW-1] && (nx_i <= LFACE) && (px_i >= LFACE)
                  && (ny_i <= lpad_s + PAD_SPAN) && (ny_i + BALL_SPAN >= lpad_s);
        l_exit  = vx[PW-1] && !l_hit && nx[PW-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            px         <= CX_FX;
            py         <= CY_FX;
            vx         <= '0;
            vy         <= '0;
            lfsr       <= 8'hA5;
            hold_cnt   <= '0;
            wall_hit   <= 1'b0;
            paddle_hit <= 1'b0;
            score_l    <= 1'b0;
            score_r    <= 1'b0;
        end else begin
            // x^8+x^6+x^5+x^4+1, free-running so serve direction depends on serve timing.
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            wall_hit   <= 1'b0;
            paddle_hit <= 1'b0;
            score_l    <= 1'b0;
            score_r    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (serve) begin
                        vx    <= lfsr[0] ? SPD0 : -SPD0;
                        vy    <= lfsr[3] ? -vy_srv : vy_srv;
                        state <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (tick) begin
                        if (r_exit || l_exit) begin
                            // Scoring wins: position frozen and no wall pulse.
                            score_l  <= r_exit;
                            score_r  <= l_exit;
                            hold_cnt <= '0;
                            state    <= S_SCORED;
                        end else begin
                            if (r_hit) begin
                                px         <= RFACE_FX;
                                vx         <= -vx_bump;
                                paddle_hit <= 1'b1;
                            end else if (l_hit) begin
                                px         <= LFACE_FX;
                                vx         <= vx_bump;
                                paddle_hit <= 1'b1;
                            end else begin
                                px <= nx;
                            end
                            if (ny[PW-1]) begin
                                py       <= '0;
                                vy       <= vy_mag;
                                wall_hit <= 1'b1;
                            end else if (ny_i > YLIM) begin
                                py       <= YLIM_FX;
                                vy       <= -vy_mag;
                                wall_hit <= 1'b1;
                            end else begin
                                py <= ny;
                            end
                        end
                    end
                end
                S_SCORED: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            px       <= CX_FX;
                            py       <= CY_FX;
                            vx       <= '0;
                            vy       <= '0;
                            state    <= S_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ball_x = px[FRAC +: XW];
    assign ball_y = py[FRAC +: YW];
    assign moving = (state == S_MOVE);

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine with default parameters; expected values hand-computed.
// Latency: one tick per do_tick call; outputs sampled on the falling edge after the tick edge.
// Backpressure: none; every wait on the DUT is bounded by a tick budget.
module tb_ball_motion_engine;
    logic       clk = 1'b0;
    logic       reset, tick, serve;
    logic [5:0] lpad_y, rpad_y;
    logic [5:0] ball_x, ball_y;
    logic       moving, wall_hit, paddle_hit, score_l, score_r;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  track    = 1'b0;

    ball_motion_engine dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .serve      (serve),
        .lpad_y     (lpad_y),
        .rpad_y     (rpad_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .moving     (moving),
        .wall_hit   (wall_hit),
        .paddle_hit (paddle_hit),
        .score_l    (score_l),
        .score_r    (score_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One frame step; when tracking, both paddles are centred on the ball first.
    task automatic do_tick();
        int t;
        @(negedge clk);
        if (track) begin
            t = int'(ball_y) - 5;
            if (t < 0) t = 0;
            if (t > 52) t = 52;
            lpad_y = 6'(t);
            rpad_y = 6'(t);
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Reset, then optionally serve on the first cycle after release (LFSR = 8'hA5).
    task automatic reset_and_serve(input bit do_serve);
        @(negedge clk);
        reset = 1'b1;
        serve = 1'b0;
        tick  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        serve = do_serve;
        @(negedge clk);
        serve = 1'b0;
    endtask

    initial begin
        int n, hits, scores, pulses;
        reset  = 1'b1;
        tick   = 1'b0;
        serve  = 1'b0;
        lpad_y = 6'd0;
        rpad_y = 6'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_x", int'(ball_x), 31);
        check("rst_y", int'(ball_y), 31);
        check("rst_moving", int'(moving), 0);
        check("rst_pulses", int'(wall_hit) + int'(paddle_hit) + int'(score_l) + int'(score_r), 0);

        // Ticks without serve do nothing
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            do_tick();
            pulses += int'(wall_hit) + int'(paddle_hit) + int'(score_l) + int'(score_r) + int'(moving);
        end
        check("idle_x", int'(ball_x), 31);
        check("idle_y", int'(ball_y), 31);
        check("idle_activity", pulses, 0);

        // Serve with L=A5: vx=+16, vy=+16; right paddle at 52
        rpad_y = 6'd52;
        lpad_y = 6'd0;
        reset_and_serve(1'b1);
        check("serve_moving", int'(moving), 1);
        do_tick();
        check("t1_x", int'(ball_x), 32);
        check("t1_y", int'(ball_y), 32);
        repeat (4) do_tick();
        check("t5_x", int'(ball_x), 36);
        check("t5_y", int'(ball_y), 36);
        hits = 0;
        for (int i = 6; i <= 26; i++) begin
            do_tick();
            hits += int'(paddle_hit);
        end
        check("early_hits", hits, 0);
        do_tick();
        check("t27_paddle_hit", int'(paddle_hit), 1);
        check("t27_x", int'(ball_x), 58);
        do_tick();
        check("t28_x", int'(ball_x), 56);
        check("t28_paddle_hit", int'(paddle_hit), 0);
        do_tick();
        check("t29_x", int'(ball_x), 55);

        // Bottom wall: y reaches 62 at tick 31, bounce flagged at tick 32
        track = 1'b1;
        n = 29;
        while (!wall_hit && n < 60) begin
            do_tick();
            n++;
        end
        check("wall_tick", n, 32);
        check("wall_y", int'(ball_y), 62);
        do_tick();
        check("wall_after_y", int'(ball_y), 61);
        check("wall_pulse_clear", int'(wall_hit), 0);

        // Rally to 20 paddle hits; hit 20 is on the left face
        hits   = 1;
        scores = 0;
        n      = 0;
        while (hits < 20 && scores == 0 && n < 4000) begin
            do_tick();
            n++;
            hits   += int'(paddle_hit);
            scores += int'(score_l) + int'(score_r);
        end
        check("rally_hits", hits, 20);
        check("rally_scores", scores, 0);
        check("hit20_x", int'(ball_x), 2);
        do_tick();
        check("cap_x1", int'(ball_x), 5);
        do_tick();
        check("cap_x2", int'(ball_x), 8);
        do_tick();
        check("cap_x3", int'(ball_x), 11);

        // Reset mid-MOVE, with tick asserted alongside
        @(negedge clk);
        reset = 1'b1;
        tick  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick  = 1'b0;
        check("midrst_x", int'(ball_x), 31);
        check("midrst_y", int'(ball_y), 31);
        check("midrst_moving", int'(moving), 0);
        check("midrst_pulses", int'(wall_hit) + int'(paddle_hit) + int'(score_l) + int'(score_r), 0);

        // Miss on the right: rpad_y=20, ball exits on tick 32
        track  = 1'b0;
        rpad_y = 6'd20;
        lpad_y = 6'd0;
        reset_and_serve(1'b1);
        hits = 0;
        for (int i = 1; i <= 31; i++) begin
            do_tick();
            hits += int'(paddle_hit) + int'(score_l) + int'(score_r);
        end
        check("miss_no_events", hits, 0);
        check("t31_x", int'(ball_x), 62);
        do_tick();
        check("score_l", int'(score_l), 1);
        check("score_r", int'(score_r), 0);
        check("score_wall_suppressed", int'(wall_hit), 0);
        check("score_moving", int'(moving), 0);
        check("score_frozen_x", int'(ball_x), 62);

        // Hold: serve ignored, recentre on the 8th tick
        @(negedge clk);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
        check("hold_serve_ignored", int'(moving), 0);
        repeat (7) do_tick();
        check("hold7_x", int'(ball_x), 62);
        check("hold7_score_clear", int'(score_l), 0);
        do_tick();
        check("recentre_x", int'(ball_x), 31);
        check("recentre_y", int'(ball_y), 31);
        check("recentre_moving", int'(moving), 0);
        do_tick();
        check("idle_after_x", int'(ball_x), 31);
        check("idle_after_moving", int'(moving), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
